step_calculator: RTL and testbench
==================================

Name: step_calculator

Overview:
- Fitness/runner telemetry accumulator.
- Each valid sample (one per second of activity) carries a heart rate, a step cadence and a stride length.
- Accumulates steps, distance, elapsed time, calories and heart-rate statistics.
- Classifies heart-rate safety and workout intensity for display/alarm logic downstream.

Parameters:
- HR_WARN, 150, heart rate (bpm) at/above which classification is Warning.
- HR_EMERG, 180, heart rate at/above which classification is Emergency.
- INT_FATBURN, 120, average HR at/above which intensity is Fat Burn.
- INT_CARDIO, 150, average HR at/above which intensity is Intense Cardio.
- CAL_SHIFT, 6, right-shift applied to hr_input*steps_per_second per sample for calories.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- hr_input  in  8  heart rate sample, bpm, unsigned.
- steps_per_second  in  2  steps taken in this one-second sample, 0..3.
- stride_length  in  8  stride length in cm, unsigned.
- valid_input  in  1  sample qualifier; one sample per clock while high.
- total_steps  out  16  accumulated steps.
- total_distance  out  32  accumulated distance, cm.
- time_elapsed  out  8  accepted sample count (seconds), saturating.
- heart_rate_classification  out  2  00 Safe, 01 Warning, 10 Emergency; 11 never driven.
- max_heart_rate  out  8  largest accepted hr_input.
- total_calories  out  32  accumulated calorie units.
- average_heart_rate  out  32  integer mean of accepted hr_input.
- workout_intensity  out  2  00 Warmup, 01 Fat Burn, 10 Intense Cardio; 11 never driven.

Behaviour:
- Reset (rst=1 at a rising edge) clears all outputs and internal state to 0 (class Safe, intensity Warmup). Reset has priority over valid_input. Reset mid-run discards all accumulation.
- Sample accepted at a rising edge with rst=0 and valid_input=1. All registered outputs reflect that sample after the same edge (1-cycle latency). No backpressure, no ready signal.
- valid_input=0: every register holds.
- Per accepted sample (unsigned arithmetic):
  - total_steps += steps_per_second, wraps mod 2^16.
  - total_distance += steps_per_second*stride_length (10-bit product, zero-extended), wraps mod 2^32.
  - time_elapsed += 1, saturating at 255.
  - hr_count (internal 16-bit) += 1, saturating at 65535.
  - hr_sum (internal 32-bit) += hr_input.
  - max_heart_rate = max(max_heart_rate, hr_input).
  - total_calories += (hr_input*steps_per_second) >> CAL_SHIFT, wraps mod 2^32.
  - heart_rate_classification from this sample's hr_input: Emergency if >= HR_EMERG, else Warning if >= HR_WARN, else Safe.
- Derived outputs (combinational from registers):
  - average_heart_rate = hr_count==0 ? 0 : floor(hr_sum/hr_count).
  - workout_intensity from average_heart_rate: Intense Cardio if >= INT_CARDIO, else Fat Burn if >= INT_FATBURN, else Warmup.
- steps_per_second=0 is a valid sample: time, count, HR stats and classification update; steps, distance and calories do not change.
- Consecutive valid cycles each count as separate samples.

Decomposition:
- Package step_calc_pkg holds:
  - classification encodings SAFE/WARNING/EMERGENCY;
  - intensity encodings WARMUP/FAT_BURN/CARDIO;
  - default threshold constants.
- One natural sub-module: hr_stats. It holds max, sum, count, average divide and the intensity decode.
- Step, distance, calorie and time accumulators and classification stay in the top.

Test Plan:
- Reset, then one sample hr=110, sps=1, stride=75 -> steps 1, distance 75, time 1, max 110, calories 1, avg 110, class Safe, intensity Warmup.
- Follow with hr=120, sps=2, stride=75 -> steps 3, distance 225, time 2, max 120, calories 4, avg 115. Then valid_input=0 for 5 cycles -> all outputs unchanged.
- Classification boundaries, one sample each -> results:
  - hr=149 -> 00
  - hr=150 -> 01
  - hr=179 -> 01
  - hr=180 -> 10
  - hr=255 -> 10
- Intensity: samples hr=200 then hr=100 -> avg 150 -> 10. Add hr=50 -> avg 116 -> 00. Max remains 200.
- Saturation/wrap:
  - 300 samples sps=0 -> time_elapsed 255, steps 0, avg exact.
  - 21846 samples sps=3 -> total_steps wraps to 2.
- Assert rst while valid_input=1 mid-run -> every output 0 the next cycle. The first post-reset sample starts accumulation from 0.

Source files
------------

// File: rtl/step_calc_pkg.sv
// Shared encodings and default thresholds for the step_calculator telemetry block.
package step_calc_pkg;

    // Heart-rate safety classification of the most recent sample
    typedef enum logic [1:0] {
        SAFE      = 2'b00,
        WARNING   = 2'b01,
        EMERGENCY = 2'b10
    } hr_class_e;

    // Workout intensity derived from the running average heart rate
    typedef enum logic [1:0] {
        WARMUP   = 2'b00,
        FAT_BURN = 2'b01,
        CARDIO   = 2'b10
    } intensity_e;

    localparam logic [7:0]  DEF_HR_WARN     = 8'd150;
    localparam logic [7:0]  DEF_HR_EMERG    = 8'd180;
    localparam logic [7:0]  DEF_INT_FATBURN = 8'd120;
    localparam logic [7:0]  DEF_INT_CARDIO  = 8'd150;
    localparam int unsigned DEF_CAL_SHIFT   = 6;

    // Emergency takes precedence over Warning
    function automatic hr_class_e classify_hr(input logic [7:0] hr,
                                              input logic [7:0] warn,
                                              input logic [7:0] emerg);
        if (hr >= emerg)
            return EMERGENCY;
        else if (hr >= warn)
            return WARNING;
        else
            return SAFE;
    endfunction

endpackage

// File: rtl/step_calculator_hr_stats.sv
// Heart-rate statistics: running max, sum, sample count, mean and intensity decode.
module hr_stats
    import step_calc_pkg::*;
#(
    parameter logic [7:0] INT_FATBURN = DEF_INT_FATBURN,
    parameter logic [7:0] INT_CARDIO  = DEF_INT_CARDIO
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sample_valid,
    input  logic [7:0]  hr,
    output logic [7:0]  max_hr,
    output logic [31:0] average_hr,
    output logic [1:0]  intensity
);

    logic [7:0]  max_q,   max_d;
    logic [31:0] sum_q,   sum_d;
    logic [15:0] count_q, count_d;
    logic [31:0] avg;
    intensity_e  intensity_w;

    // Next-state for the statistics accumulators; count saturates, sum wraps
    always_comb begin
        max_d   = max_q;
        sum_d   = sum_q;
        count_d = count_q;
        if (sample_valid) begin
            if (hr > max_q)
                max_d = hr;
            sum_d = sum_q + {24'b0, hr};
            if (count_q != '1)
                count_d = count_q + 16'd1;
        end
    end

    // Statistics registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            max_q   <= '0;
            sum_q   <= '0;
            count_q <= '0;
        end else begin
            max_q   <= max_d;
            sum_q   <= sum_d;
            count_q <= count_d;
        end
    end

    // Integer mean (zero before any sample) and intensity band from that mean
    always_comb begin
        avg = '0;
        if (count_q != '0)
            avg = sum_q / {16'b0, count_q};
        if (avg >= {24'b0, INT_CARDIO})
            intensity_w = CARDIO;
        else if (avg >= {24'b0, INT_FATBURN})
            intensity_w = FAT_BURN;
        else
            intensity_w = WARMUP;
    end

    assign max_hr     = max_q;
    assign average_hr = avg;
    assign intensity  = intensity_w;

endmodule

// File: rtl/step_calculator.sv
// Runner telemetry accumulator: steps, distance, time, calories and HR classification.
module step_calculator
    import step_calc_pkg::*;
#(
    parameter logic [7:0]  HR_WARN     = DEF_HR_WARN,
    parameter logic [7:0]  HR_EMERG    = DEF_HR_EMERG,
    parameter logic [7:0]  INT_FATBURN = DEF_INT_FATBURN,
    parameter logic [7:0]  INT_CARDIO  = DEF_INT_CARDIO,
    parameter int unsigned CAL_SHIFT   = DEF_CAL_SHIFT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  hr_input,
    input  logic [1:0]  steps_per_second,
    input  logic [7:0]  stride_length,
    input  logic        valid_input,
    output logic [15:0] total_steps,
    output logic [31:0] total_distance,
    output logic [7:0]  time_elapsed,
    output logic [1:0]  heart_rate_classification,
    output logic [7:0]  max_heart_rate,
    output logic [31:0] total_calories,
    output logic [31:0] average_heart_rate,
    output logic [1:0]  workout_intensity
);

    logic [15:0] steps_q, steps_d;
    logic [31:0] dist_q,  dist_d;
    logic [7:0]  time_q,  time_d;
    logic [31:0] cal_q,   cal_d;
    hr_class_e   class_q, class_d;

    logic [9:0]  dist_inc;
    logic [9:0]  cal_prod;
    logic [9:0]  cal_inc;

    // Per-sample increments and next-state of the activity accumulators
    always_comb begin
        dist_inc = {8'b0, steps_per_second} * {2'b0, stride_length};
        cal_prod = {8'b0, steps_per_second} * {2'b0, hr_input};
        cal_inc  = cal_prod >> CAL_SHIFT;

        steps_d = steps_q;
        dist_d  = dist_q;
        time_d  = time_q;
        cal_d   = cal_q;
        class_d = class_q;
        if (valid_input) begin
            steps_d = steps_q + {14'b0, steps_per_second};
            dist_d  = dist_q + {22'b0, dist_inc};
            if (time_q != '1)
                time_d = time_q + 8'd1;
            cal_d   = cal_q + {22'b0, cal_inc};
            class_d = classify_hr(hr_input, HR_WARN, HR_EMERG);
        end
    end

    // Accumulator registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            steps_q <= '0;
            dist_q  <= '0;
            time_q  <= '0;
            cal_q   <= '0;
            class_q <= SAFE;
        end else begin
            steps_q <= steps_d;
            dist_q  <= dist_d;
            time_q  <= time_d;
            cal_q   <= cal_d;
            class_q <= class_d;
        end
    end

    hr_stats #(
        .INT_FATBURN (INT_FATBURN),
        .INT_CARDIO  (INT_CARDIO)
    ) u_hr_stats (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (valid_input),
        .hr           (hr_input),
        .max_hr       (max_heart_rate),
        .average_hr   (average_heart_rate),
        .intensity    (workout_intensity)
    );

    assign total_steps               = steps_q;
    assign total_distance            = dist_q;
    assign time_elapsed              = time_q;
    assign total_calories            = cal_q;
    assign heart_rate_classification = class_q;

endmodule

// File: tb/tb_step_calculator.sv
// Self-checking bench for step_calculator against a plain-arithmetic reference model.
module tb_step_calculator;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  hr_input = '0;
    logic [1:0]  steps_per_second = '0;
    logic [7:0]  stride_length = '0;
    logic        valid_input = 1'b0;
    logic [15:0] total_steps;
    logic [31:0] total_distance;
    logic [7:0]  time_elapsed;
    logic [1:0]  heart_rate_classification;
    logic [7:0]  max_heart_rate;
    logic [31:0] total_calories;
    logic [31:0] average_heart_rate;
    logic [1:0]  workout_intensity;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    longint m_steps, m_dist, m_time, m_count, m_sum, m_max, m_cal, m_class;

    localparam longint TWO32 = 64'd4294967296;

    always #5 clk = ~clk;

    step_calculator dut (
        .clk                       (clk),
        .rst                       (rst),
        .hr_input                  (hr_input),
        .steps_per_second          (steps_per_second),
        .stride_length             (stride_length),
        .valid_input               (valid_input),
        .total_steps               (total_steps),
        .total_distance            (total_distance),
        .time_elapsed              (time_elapsed),
        .heart_rate_classification (heart_rate_classification),
        .max_heart_rate            (max_heart_rate),
        .total_calories            (total_calories),
        .average_heart_rate        (average_heart_rate),
        .workout_intensity         (workout_intensity)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint model_avg();
        return (m_count == 0) ? 0 : m_sum / m_count;
    endfunction

    function automatic longint model_int();
        longint a;
        a = model_avg();
        return (a >= 150) ? 2 : (a >= 120) ? 1 : 0;
    endfunction

    task automatic model_clear();
        m_steps = 0; m_dist = 0; m_time = 0; m_count = 0;
        m_sum = 0; m_max = 0; m_cal = 0; m_class = 0;
    endtask

    task automatic model_sample(input longint h, input longint s, input longint st);
        m_steps = (m_steps + s) % 65536;
        m_dist  = (m_dist + s * st) % TWO32;
        if (m_time < 255) m_time++;
        if (m_count < 65535) m_count++;
        m_sum   = (m_sum + h) % TWO32;
        if (h > m_max) m_max = h;
        m_cal   = (m_cal + (h * s) / 64) % TWO32;
        m_class = (h >= 180) ? 2 : (h >= 150) ? 1 : 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".steps"}, {16'b0, total_steps},               32'(m_steps));
        chk({tag, ".dist"},  total_distance,                     32'(m_dist));
        chk({tag, ".time"},  {24'b0, time_elapsed},              32'(m_time));
        chk({tag, ".class"}, {30'b0, heart_rate_classification}, 32'(m_class));
        chk({tag, ".max"},   {24'b0, max_heart_rate},            32'(m_max));
        chk({tag, ".cal"},   total_calories,                     32'(m_cal));
        chk({tag, ".avg"},   average_heart_rate,                 32'(model_avg()));
        chk({tag, ".int"},   {30'b0, workout_intensity},         32'(model_int()));
    endtask

    // One clock: drive at negedge, model follows the edge, optional check 1ns after it
    task automatic cycle(input logic r, input logic v, input logic [7:0] h,
                         input logic [1:0] s, input logic [7:0] st,
                         input bit do_chk, input string tag);
        @(negedge clk);
        rst = r; valid_input = v; hr_input = h; steps_per_second = s; stride_length = st;
        @(posedge clk);
        if (r) model_clear();
        else if (v) model_sample(longint'(h), longint'(s), longint'(st));
        #1;
        if (do_chk) check_all(tag);
    endtask

    initial begin
        logic [7:0] bnd [5];
        model_clear();

        // Reset state
        cycle(1'b1, 1'b0, 8'd0, 2'd0, 8'd0, 1'b0, "rst");
        cycle(1'b1, 1'b0, 8'd0, 2'd0, 8'd0, 1'b1, "reset");

        // First two samples with explicit expectations
        cycle(1'b0, 1'b1, 8'd110, 2'd1, 8'd75, 1'b1, "s1");
        chk("s1.steps_c", {16'b0, total_steps}, 32'd1);
        chk("s1.dist_c",  total_distance,       32'd75);
        chk("s1.cal_c",   total_calories,       32'd1);
        cycle(1'b0, 1'b1, 8'd120, 2'd2, 8'd75, 1'b1, "s2");
        chk("s2.dist_c", total_distance,     32'd225);
        chk("s2.cal_c",  total_calories,     32'd4);
        chk("s2.avg_c",  average_heart_rate, 32'd115);

        // Idle cycles hold everything, even with garbage on the data inputs
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b0, 8'($urandom), 2'($urandom), 8'($urandom), 1'b1, "idle");

        // Classification boundaries
        bnd[0] = 8'd149; bnd[1] = 8'd150; bnd[2] = 8'd179; bnd[3] = 8'd180; bnd[4] = 8'd255;
        for (int i = 0; i < 5; i++)
            cycle(1'b0, 1'b1, bnd[i], 2'd1, 8'd60, 1'b1, "bound");

        // Intensity bands
        cycle(1'b1, 1'b0, 8'd0, 2'd0, 8'd0, 1'b0, "rst");
        cycle(1'b0, 1'b1, 8'd200, 2'd1, 8'd80, 1'b0, "i1");
        cycle(1'b0, 1'b1, 8'd100, 2'd1, 8'd80, 1'b1, "i2");
        chk("i2.avg_c", average_heart_rate,         32'd150);
        chk("i2.int_c", {30'b0, workout_intensity}, 32'd2);
        cycle(1'b0, 1'b1, 8'd50, 2'd1, 8'd80, 1'b1, "i3");
        chk("i3.avg_c", average_heart_rate,         32'd116);
        chk("i3.int_c", {30'b0, workout_intensity}, 32'd0);
        chk("i3.max_c", {24'b0, max_heart_rate},    32'd200);

        // Time saturation with zero-step samples
        cycle(1'b1, 1'b0, 8'd0, 2'd0, 8'd0, 1'b0, "rst");
        for (int i = 0; i < 300; i++)
            cycle(1'b0, 1'b1, 8'($urandom_range(40, 220)), 2'd0, 8'($urandom), i >= 250, "sat");
        chk("sat.time_c", {24'b0, time_elapsed}, 32'd255);

        // Step counter wrap
        cycle(1'b1, 1'b0, 8'd0, 2'd0, 8'd0, 1'b0, "rst");
        for (int i = 0; i < 21846; i++)
            cycle(1'b0, 1'b1, 8'($urandom), 2'd3, 8'($urandom), 1'b0, "wrap");
        #1;
        check_all("wrap");
        chk("wrap.steps_c", {16'b0, total_steps}, 32'd2);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 400; i++)
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
                  8'($urandom), 2'($urandom), 8'($urandom), 1'b1, "rand");

        // Reset asserted together with valid mid-run, then restart from zero
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b1, 8'($urandom), 2'($urandom), 8'($urandom), 1'b0, "pre");
        cycle(1'b1, 1'b1, 8'd170, 2'd3, 8'd90, 1'b1, "midrst");
        chk("midrst.steps_c", {16'b0, total_steps}, 32'd0);
        cycle(1'b0, 1'b1, 8'd160, 2'd2, 8'd50, 1'b1, "post");
        chk("post.dist_c", total_distance, 32'd100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
